// File: rtl/path_replayer.sv
// Replays a solved maze path from (0,0), one popped Move per step, and streams every
// visited cell on a valid/ready port; flags saturation errors and whether the path ends on the finish cell.
module path_replayer #(
   parameter int N              = 4,
   parameter int DIRECTION_SIZE = 2,
   parameter int CNT_W          = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic [DIRECTION_SIZE-1:0] Move,
   input  logic                      complete_read,
   output logic                      en_read,
   output logic [N-1:0]              out_x,
   output logic [N-1:0]              out_y,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CNT_W-1:0]          steps,
   output logic                      done,
   output logic                      path_ok,
   output logic                      error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EMIT  = 3'd1,
      S_CHECK = 3'd2,
      S_STEP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [N-1:0]              MAX_C   = {N{1'b1}};
   localparam logic [N-1:0]              ZERO_C  = {N{1'b0}};
   localparam logic [CNT_W-1:0]          MAX_CNT = {CNT_W{1'b1}};
   localparam logic [DIRECTION_SIZE-1:0] MV_YDEC = DIRECTION_SIZE'(2'b00);
   localparam logic [DIRECTION_SIZE-1:0] MV_XINC = DIRECTION_SIZE'(2'b01);
   localparam logic [DIRECTION_SIZE-1:0] MV_XDEC = DIRECTION_SIZE'(2'b10);
   localparam logic [DIRECTION_SIZE-1:0] MV_YINC = DIRECTION_SIZE'(2'b11);

   state_t           r_state;
   state_t           w_next;
   logic [N-1:0]     r_x;
   logic [N-1:0]     r_y;
   logic [CNT_W-1:0] r_steps;
   logic             r_error;
   logic             r_path_ok;
   logic             r_done;
   logic             r_out_valid;
   logic             r_en_read;
   logic [N-1:0]     w_nx;
   logic [N-1:0]     w_ny;
   logic             w_wrap;
   logic             w_sat;
   logic             w_end_ok;
   logic             w_start_ok;

   assign w_sat      = (r_steps == MAX_CNT);
   assign w_end_ok   = (r_x == MAX_C) && (r_y == MAX_C) && !r_error;
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next = S_EMIT;
            end else begin
               w_next = r_state;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               w_next = S_CHECK;
            end else begin
               w_next = S_EMIT;
            end
         end
         S_CHECK: begin
            if (complete_read) begin
               w_next = S_DONE;
            end else begin
               w_next = S_STEP;
            end
         end
         S_STEP:  w_next = S_EMIT;
         default: w_next = S_IDLE;
      endcase
   end

   // Next cell: a move off the grid edge saturates and is reported as a wrap
   always_comb begin
      w_nx   = r_x;
      w_ny   = r_y;
      w_wrap = 1'b0;
      case (Move)
         MV_YDEC: begin
            if (r_y == ZERO_C) begin
               w_wrap = 1'b1;
            end else begin
               w_ny = r_y - N'(1);
            end
         end
         MV_XINC: begin
            if (r_x == MAX_C) begin
               w_wrap = 1'b1;
            end else begin
               w_nx = r_x + N'(1);
            end
         end
         MV_XDEC: begin
            if (r_x == ZERO_C) begin
               w_wrap = 1'b1;
            end else begin
               w_nx = r_x - N'(1);
            end
         end
         MV_YINC: begin
            if (r_y == MAX_C) begin
               w_wrap = 1'b1;
            end else begin
               w_ny = r_y + N'(1);
            end
         end
         default: begin
            w_wrap = 1'b0;
         end
      endcase
   end

   // Datapath and registered status outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_x         <= ZERO_C;
         r_y         <= ZERO_C;
         r_steps     <= {CNT_W{1'b0}};
         r_error     <= 1'b0;
         r_path_ok   <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_en_read   <= 1'b0;
      end else begin
         r_done      <= (w_next == S_DONE);
         r_out_valid <= (w_next == S_EMIT);
         // the pop strobe lines up exactly with the STEP cycle
         r_en_read   <= (w_next == S_STEP) && !complete_read;
         if (w_start_ok) begin
            r_x       <= ZERO_C;
            r_y       <= ZERO_C;
            r_steps   <= {CNT_W{1'b0}};
            r_error   <= 1'b0;
            r_path_ok <= 1'b0;
         end else if ((r_state == S_STEP) && !complete_read) begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_sat) begin
               r_steps <= r_steps;
            end else begin
               r_steps <= r_steps + CNT_W'(1);
            end
            r_error <= r_error | w_wrap | w_sat;
         end else if ((r_state == S_CHECK) && complete_read) begin
            r_path_ok <= w_end_ok;
         end else begin
            r_x <= r_x;
         end
      end
   end

   assign en_read   = r_en_read;
   assign out_x     = r_x;
   assign out_y     = r_y;
   assign out_valid = r_out_valid;
   assign steps     = r_steps;
   assign done      = r_done;
   assign path_ok   = r_path_ok;
   assign error     = r_error;

endmodule
